// File: rtl/lrf_frame_streamer.sv
// AXI4-Stream source for the LRF fusion input: reads FUSE_COUNT frames from a synchronous-read
// frame memory through a 2-entry skid FIFO and emits them back to back with tuser/tlast tags.
module lrf_frame_streamer #(
    parameter  int PIXELS_PER_BEAT = 16,
    parameter  int IMAGE_DIM       = 512,
    parameter  int FUSE_COUNT      = 16,
    parameter  int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    localparam int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    localparam int ADDR_WIDTH      = $clog2(FUSE_COUNT * BEATS_PER_FRAME),
    localparam int FIDX_WIDTH      = (FUSE_COUNT > 1) ? $clog2(FUSE_COUNT) : 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [FIDX_WIDTH-1:0] frame_idx,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    localparam int BEAT_WIDTH = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam logic [ADDR_WIDTH:0]   TOTAL_BEATS = (ADDR_WIDTH + 1)'(FUSE_COUNT * BEATS_PER_FRAME);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT   = BEAT_WIDTH'(BEATS_PER_FRAME - 1);
    localparam logic [FIDX_WIDTH-1:0] LAST_FRAME  = FIDX_WIDTH'(FUSE_COUNT - 1);

    if ((IMAGE_DIM * IMAGE_DIM) % PIXELS_PER_BEAT != 0) begin : g_bad_beat_size
        $error("IMAGE_DIM*IMAGE_DIM must be a multiple of PIXELS_PER_BEAT");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
    logic [FIDX_WIDTH-1:0]   frame_q, frame_d;
    logic                    done_q, done_d;

    logic                    inflight_q;
    logic                    inf_user_q, inf_last_q;
    logic [FIDX_WIDTH-1:0]   inf_frame_q;

    logic [DATA_WIDTH-1:0]   fifo_data_q  [2];
    logic                    fifo_last_q  [2];
    logic                    fifo_user_q  [2];
    logic [FIDX_WIDTH-1:0]   fifo_frame_q [2];
    logic [1:0]              count_q, count_d;
    logic                    wr_sel_q, rd_sel_q;

    logic                    push, pop, issue, final_beat;
    logic [2:0]              occ_next;

    assign push          = inflight_q;
    assign m_axis_tvalid = (count_q != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;

    // Occupancy seen by the read issuer already credits this cycle's pop, so the
    // skid FIFO refills in step with the sink and the stream has no bubbles.
    assign occ_next = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue    = (state_q == S_FETCH) && (rd_ptr_q != TOTAL_BEATS) && (occ_next < 3'd2);

    assign final_beat = pop && fifo_last_q[rd_sel_q] && (fifo_frame_q[rd_sel_q] == LAST_FRAME);
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // done_q blocks a start landing in the completion cycle.
                if (start && !done_q) begin
                    state_d  = S_FETCH;
                    rd_ptr_d = '0;
                    beat_d   = '0;
                    frame_d  = '0;
                end
            end
            S_FETCH: begin
                if (rd_ptr_q == TOTAL_BEATS) begin
                    state_d = S_DRAIN;
                end else if (issue) begin
                    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        frame_d = frame_q + FIDX_WIDTH'(1);
                    end else begin
                        beat_d = beat_q + BEAT_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (final_beat) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            beat_q      <= '0;
            frame_q     <= '0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            inf_user_q  <= 1'b0;
            inf_last_q  <= 1'b0;
            inf_frame_q <= '0;
            count_q     <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
            inflight_q <= issue;
            if (issue) begin
                inf_user_q  <= (beat_q == '0);
                inf_last_q  <= (beat_q == LAST_BEAT);
                inf_frame_q <= frame_q;
            end
            count_q <= count_d;
            if (push) wr_sel_q <= ~wr_sel_q;
            if (pop)  rd_sel_q <= ~rd_sel_q;
        end
    end

    // NOTE: FIFO storage has no reset; outputs are gated by tvalid, so stale entries never leak.
    always_ff @(posedge s_axis_aclk) begin
        if (push) begin
            fifo_data_q[wr_sel_q]  <= mem_rdata;
            fifo_last_q[wr_sel_q]  <= inf_last_q;
            fifo_user_q[wr_sel_q]  <= inf_user_q;
            fifo_frame_q[wr_sel_q] <= inf_frame_q;
        end
    end

    assign m_axis_tdata = m_axis_tvalid ? fifo_data_q[rd_sel_q]  : '0;
    assign m_axis_tlast = m_axis_tvalid ? fifo_last_q[rd_sel_q]  : 1'b0;
    assign m_axis_tuser = m_axis_tvalid ? fifo_user_q[rd_sel_q]  : 1'b0;
    assign frame_idx    = m_axis_tvalid ? fifo_frame_q[rd_sel_q] : '0;

    assign mem_en   = issue;
    assign mem_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule
